// File: rtl/count_pkg.sv
// Shared definitions for the 4-bit free-running counter and the blocks that consume its value.
package count_pkg;

    localparam int COUNT_W = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;

    // Only a natural roll-over (max -> 0) is a wrap; any other jump is ignored.
    function automatic logic is_wrap(input logic [COUNT_W-1:0] prev, input logic [COUNT_W-1:0] cur);
        return (prev == COUNT_MAX) && (cur == '0);
    endfunction

endpackage

// File: rtl/count_snapshot_fifo_if.sv
// Snapshot stream: the master holds data steady while valid=1 and ready=0; a beat moves when valid && ready.
interface count_snapshot_fifo_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered outputs; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible once level says so.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/count_snapshot_fifo.sv
// Extends a 4-bit counter with a wrap epoch and queues {epoch, count} snapshots on capture rising edges.
module count_snapshot_fifo
    import count_pkg::*;
#(
    parameter int EPOCH_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_W-1:0]     count_in,
    input  logic                   capture,
    input  logic                   clear_ovf,
    count_snapshot_fifo_if.master  out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int ENTRY_W = EPOCH_W + COUNT_W;
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [COUNT_W-1:0] prev_count_q, prev_count_d;
    logic               cap_prev_q, cap_prev_d;
    logic               overflow_q, overflow_d;

    logic               wrap, cap_edge, pop, drop, fifo_push;
    logic               fifo_full, fifo_empty;
    logic [EPOCH_W-1:0] ep_eff;
    logic [ENTRY_W-1:0] entry, fifo_dout;

    always_comb begin
        wrap      = is_wrap(prev_count_q, count_in);
        ep_eff    = wrap ? (epoch_q + EPOCH_ONE) : epoch_q;
        cap_edge  = capture && !cap_prev_q;
        pop       = out_if.valid && out_if.ready;
        // A full FIFO only loses the snapshot if nothing leaves in the same cycle.
        drop      = cap_edge && fifo_full && !pop;
        fifo_push = cap_edge && !drop;
        entry     = {ep_eff, count_in};
    end

    always_comb begin
        epoch_d      = ep_eff;
        prev_count_d = count_in;
        cap_prev_d   = capture;
        overflow_d   = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_q      <= '0;
            prev_count_q <= '0;
            cap_prev_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            epoch_q      <= epoch_d;
            prev_count_q <= prev_count_d;
            cap_prev_q   <= cap_prev_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .din   (entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_if.valid = !fifo_empty;
    assign out_if.data  = fifo_dout;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo: a 4-bit-epoch instance and a 2-bit-epoch instance share stimulus.
module tb_count_snapshot_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       capture;
    logic       clear_ovf;
    logic [2:0] level4, level2;
    logic       overflow4, overflow2;

    int n_cmp = 0;
    int n_bad = 0;

    count_snapshot_fifo_if #(.DATA_W(8)) if4 ();
    count_snapshot_fifo_if #(.DATA_W(6)) if2 ();

    assign if2.ready = if4.ready;

    count_snapshot_fifo #(.EPOCH_W(4), .DEPTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .capture   (capture),
        .clear_ovf (clear_ovf),
        .out_if    (if4),
        .level     (level4),
        .overflow  (overflow4)
    );

    count_snapshot_fifo #(.EPOCH_W(2), .DEPTH(4)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .capture   (capture),
        .clear_ovf (clear_ovf),
        .out_if    (if2),
        .level     (level2),
        .overflow  (overflow2)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // one-cycle capture pulse at value v, then one idle cycle
    task automatic pulse(input logic [3:0] v);
        count_in = v;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        if4.ready = 1'b1;
        tick();
        if4.ready = 1'b0;
    endtask

    initial begin
        count_in  = 4'h0;
        capture   = 1'b0;
        clear_ovf = 1'b0;
        if4.ready = 1'b0;

        // 1: reset state, single capture, latency, pop
        do_reset();
        check("rst_valid", 32'(if4.valid), 32'h0);
        check("rst_level", 32'(level4), 32'h0);
        check("rst_ovf", 32'(overflow4), 32'h0);
        count_in = 4'h5;
        capture  = 1'b1;
        tick();
        check("t1_valid", 32'(if4.valid), 32'h1);
        check("t1_data", 32'(if4.data), 32'h05);
        check("t1_level", 32'(level4), 32'h1);
        capture   = 1'b0;
        if4.ready = 1'b1;
        tick();
        if4.ready = 1'b0;
        check("t1_pop_valid", 32'(if4.valid), 32'h0);
        check("t1_pop_level", 32'(level4), 32'h0);

        // 2: epoch tracking, capture in the 15->0 cycle and later at count 2
        do_reset();
        for (int i = 0; i < 36; i++) begin
            count_in = 4'(i % 16);
            capture  = (i == 16) || (i == 34);
            tick();
        end
        capture = 1'b0;
        check("t2_level", 32'(level4), 32'h2);
        check("t2_wrap_cycle", 32'(if4.data), 32'h10);
        check("t2_wrap_cycle_e2", 32'(if2.data), 32'h10);
        pop_one();
        check("t2_epoch2", 32'(if4.data), 32'h22);
        pop_one();
        check("t2_empty", 32'(if4.valid), 32'h0);

        // 3: held capture makes one entry; re-raise makes another
        count_in = 4'h7;
        capture  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t3_held_level", 32'(level4), 32'h1);
        check("t3_held_data", 32'(if4.data), 32'h27);
        capture = 1'b0;
        tick();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("t3_reraise_level", 32'(level4), 32'h2);
        pop_one();
        pop_one();
        check("t3_drained", 32'(level4), 32'h0);

        // 4: overflow on fifth edge, in-order drain, clear
        pulse(4'h1);
        pulse(4'h3);
        pulse(4'h5);
        pulse(4'h7);
        check("t4_ovf_before", 32'(overflow4), 32'h0);
        pulse(4'h9);
        check("t4_level", 32'(level4), 32'h4);
        check("t4_ovf", 32'(overflow4), 32'h1);
        check("t4_d0", 32'(if4.data), 32'h21);
        pop_one();
        check("t4_d1", 32'(if4.data), 32'h23);
        pop_one();
        check("t4_d2", 32'(if4.data), 32'h25);
        pop_one();
        check("t4_d3", 32'(if4.data), 32'h27);
        pop_one();
        check("t4_empty", 32'(level4), 32'h0);
        check("t4_ovf_sticky", 32'(overflow4), 32'h1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("t4_ovf_clear", 32'(overflow4), 32'h0);

        // 5: full with simultaneous push+pop, then drop concurrent with clear
        pulse(4'h1);
        pulse(4'h2);
        pulse(4'h3);
        pulse(4'h4);
        check("t5_full", 32'(level4), 32'h4);
        count_in  = 4'h5;
        capture   = 1'b1;
        if4.ready = 1'b1;
        tick();
        capture   = 1'b0;
        if4.ready = 1'b0;
        check("t5_pp_level", 32'(level4), 32'h4);
        check("t5_pp_ovf", 32'(overflow4), 32'h0);
        check("t5_pp_head", 32'(if4.data), 32'h22);
        pop_one();
        check("t5_d3", 32'(if4.data), 32'h23);
        pop_one();
        check("t5_d4", 32'(if4.data), 32'h24);
        pop_one();
        check("t5_tail", 32'(if4.data), 32'h25);
        pop_one();
        check("t5_empty", 32'(level4), 32'h0);
        pulse(4'h6);
        pulse(4'h7);
        pulse(4'h8);
        pulse(4'h9);
        count_in  = 4'hA;
        capture   = 1'b1;
        clear_ovf = 1'b1;
        tick();
        capture   = 1'b0;
        clear_ovf = 1'b0;
        check("t5_set_over_clear", 32'(overflow4), 32'h1);
        check("t5_drop_level", 32'(level4), 32'h4);
        check("t5_drop_head", 32'(if4.data), 32'h26);

        // 6: reset overrides pending pop and capture edge
        pop_one();
        check("t6_level3", 32'(level4), 32'h3);
        reset     = 1'b1;
        capture   = 1'b1;
        if4.ready = 1'b1;
        tick();
        reset     = 1'b0;
        if4.ready = 1'b0;
        check("t6_rst_level", 32'(level4), 32'h0);
        check("t6_rst_valid", 32'(if4.valid), 32'h0);
        check("t6_rst_ovf", 32'(overflow4), 32'h0);
        count_in = 4'h3;
        tick();
        capture = 1'b0;
        check("t6_first_cycle_edge", 32'(level4), 32'h1);
        check("t6_epoch0", 32'(if4.data), 32'h03);

        // 6b: 2-bit epoch wraps 3->0 after four counter wraps
        do_reset();
        for (int i = 0; i < 65; i++) begin
            count_in = 4'(i % 16);
            capture  = (i == 49) || (i == 64);
            tick();
        end
        capture = 1'b0;
        check("t6_e2_level", 32'(level2), 32'h2);
        check("t6_e2_ep3", 32'(if2.data), 32'h31);
        check("t6_e4_ep3", 32'(if4.data), 32'h31);
        pop_one();
        check("t6_e2_wrap0", 32'(if2.data), 32'h00);
        check("t6_e4_ep4", 32'(if4.data), 32'h40);
        pop_one();
        check("t6_e2_empty", 32'(if2.valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
Downstream consumer of the 4-bit free-running counter. It tracks counter wrap-arounds in an epoch register and detects rising edges on a capture strobe. On each capture it stores the pair {epoch, count} in a small FIFO. A consumer drains the FIFO over a valid/ready interface. The block gives software/bench logic extended-range timestamps of events without widening the counter.

Parameters:
EPOCH_W, 4, width of wrap (epoch) counter; wraps modulo 2^EPOCH_W
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
count_in  input  4  counter value from the upstream counter
capture  input  1  event strobe; rising edge requests a snapshot
clear_ovf  input  1  clears sticky overflow flag
out_valid  output  1  FIFO head holds a valid entry
out_ready  input  1  consumer accepts head entry
out_data  output  EPOCH_W+4  head entry {epoch, count}; count in [3:0]
level  output  $clog2(DEPTH)+1  number of stored entries
overflow  output  1  sticky; a capture was dropped because FIFO was full

Behaviour:
- Reset (synchronous, reset=1 at a clk edge): epoch=0, prev_count=0, capture_d=0, FIFO empty, out_valid=0, level=0, overflow=0. out_data is don't-care while out_valid=0. Reset overrides all other inputs in the same cycle, including a concurrent push or pop. Entries in flight are discarded.
- Wrap detect: wrap = (prev_count==4'hF && count_in==4'h0). prev_count <= count_in every cycle. On wrap, epoch <= epoch+1, wrapping silently from 2^EPOCH_W-1 to 0. Count jumps that are not 15->0 (e.g. upstream reset) never increment epoch.
- Effective epoch: ep_eff = wrap ? epoch+1 : epoch (combinational). A capture in the wrap cycle tags the new epoch.
- Edge detect: cap_edge = capture && !capture_d; capture_d <= capture. A held-high capture produces exactly one snapshot. capture high during the first cycle after reset counts as an edge.
- Push: on cap_edge, entry = {ep_eff, count_in}.
- Pop: pop = out_valid && out_ready. out_valid = (level!=0). out_data is the oldest entry and is stable while out_valid=1 and out_ready=0.
- Latency: capture edge at cycle N into an empty FIFO -> out_valid=1 with that entry at cycle N+1. No combinational path from capture to out_valid.
- Full (level==DEPTH) with cap_edge and pop in the same cycle: both occur, level unchanged, no overflow.
- Full with cap_edge and no pop: entry dropped, overflow <= 1, FIFO unchanged.
- Empty with cap_edge and out_ready=1: no bypass. Entry appears next cycle; level becomes 1.
- overflow: set has priority over clear_ovf in the same cycle. Otherwise clear_ovf=1 -> overflow <= 0.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package count_pkg: COUNT_W=4, COUNT_MAX=4'hF. The upstream counter and this block both use it.
- ENTRY_W = EPOCH_W+COUNT_W is a localparam in this block.
- One sub-module: sync_fifo (params WIDTH, DEPTH; ports clk, reset, push, pop, din, dout, full, empty, level).
- Wrap/edge/overflow logic stays in the top level.

Test Plan:
1. Reset, then a single capture pulse when count_in=4'h5, epoch=0 -> next cycle out_valid=1, out_data={0,4'h5}, level=1. After a pop with out_ready=1, out_valid=0 and level=0.
2. Drive count_in 0..15,0..15,0..3 incrementing each cycle, then capture at count_in=4'h2 -> out_data={2,4'h2}. Also capture in the exact 15->0 cycle -> out_data={1,4'h0}.
3. capture held high for 10 cycles -> level=1 (one entry only). Drop and re-raise -> level=2.
4. out_ready=0, 5 capture edges at counts 1,3,5,7,9 -> level=4, overflow=1. Drain -> data 1,3,5,7 in order. clear_ovf -> overflow=0.
5. FIFO full, then cap_edge with out_ready=1 in the same cycle -> level stays 4, overflow stays 0, head advances, new entry at tail. A drop concurrent with clear_ovf -> overflow=1.
6. Assert reset with level=3 and capture edge pending -> next cycle level=0, out_valid=0, overflow=0, epoch=0. Verify with EPOCH_W=2 that epoch wraps 3->0 after 4 counter wraps.
